chunked_adder_subtractor: RTL and testbench

Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits per clock, LSB chunk first, through a chain of CHUNK one-bit full-adder cells and a registered inter-chunk carry. It trades latency for area in datapaths where a full-width ripple chain would miss timing. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It produces the sum or difference plus carry, signed-overflow and zero flags.

---
 rtl/chunked_adder_subtractor.sv | 119 +++++++++++
 tb/tb_chunked_adder_subtractor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/chunked_adder_subtractor.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock LSB-first through a full-adder chain.
// Latency: out_valid rises NCHUNK edges after accept; minimum NCHUNK+2 cycles per operation.
// Backpressure: result and flags held in DONE until out_ready; in_ready low outside IDLE.
module chunked_adder_subtractor #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               carry;
    logic [IDX_W-1:0]   idx;

    logic [CHUNK-1:0]   chunk_a;
    logic [CHUNK-1:0]   chunk_b;
    logic [CHUNK-1:0]   chunk_sum;
    logic [CHUNK:0]     chain;
    logic [WIDTH-1:0]   z_nxt;
    logic               last;

    // One-bit full-adder cells; chain[k] is the carry into bit k of the chunk.
    always_comb begin
        chunk_a   = opa[idx*CHUNK +: CHUNK];
        chunk_b   = opb[idx*CHUNK +: CHUNK];
        chunk_sum = '0;
        chain     = '0;
        chain[0]  = carry;
        for (int k = 0; k < CHUNK; k++) begin
            chunk_sum[k] = chunk_a[k] ^ chunk_b[k] ^ chain[k];
            chain[k+1]   = (chunk_a[k] & chunk_b[k]) | (chain[k] & (chunk_a[k] ^ chunk_b[k]));
        end
        z_nxt                      = z;
        z_nxt[idx*CHUNK +: CHUNK]  = chunk_sum;
    end

    assign last      = (idx == IDX_W'(NCHUNK - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            z     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract as A + ~B + 1: the +1 enters through the initial carry.
                        opa   <= a;
                        opb   <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    z     <= z_nxt;
                    carry <= chain[CHUNK];
                    idx   <= idx + IDX_W'(1);
                    if (last) begin
                        cout <= chain[CHUNK];
                        ovf  <= chain[CHUNK-1] ^ chain[CHUNK];
                        zero <= (z_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder_subtractor.sv
// Randomized check of chunked_adder_subtractor against an arithmetic reference model.
// Two instances: WIDTH=8/CHUNK=4 (two chunks) and WIDTH=8/CHUNK=8 (single chunk).
module tb_chunked_adder_subtractor;

    logic       clk;
    logic       rst_n;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] a_i       [2];
    logic [7:0] b_i       [2];
    logic       sub_i     [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] z_o       [2];
    logic       cout_o    [2];
    logic       ovf_o     [2];
    logic       zero_o    [2];

    int n_checks = 0;
    int n_fail   = 0;
    int nchunk [2] = '{2, 1};

    chunked_adder_subtractor #(.WIDTH(8), .CHUNK(4)) u_dut_c4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_i[0]), .b(b_i[0]), .sub(sub_i[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .z(z_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0])
    );

    chunked_adder_subtractor #(.WIDTH(8), .CHUNK(8)) u_dut_c8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_i[1]), .b(b_i[1]), .sub(sub_i[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .z(z_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]), .zero(zero_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {zero, ovf, cout, z} from plain 8-bit arithmetic.
    function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [8:0] full;
        logic [7:0] r;
        logic       co;
        logic       ov;
        if (!s) begin
            full = {1'b0, x} + {1'b0, y};
            r    = full[7:0];
            co   = full[8];
            ov   = (x[7] == y[7]) && (r[7] != x[7]);
        end else begin
            r    = x - y;
            co   = (x >= y);
            ov   = (x[7] != y[7]) && (r[7] != x[7]);
        end
        return {(r == 8'h00), ov, co, r};
    endfunction

    task automatic check_result(input int d, input string tag, input logic [10:0] exp);
        check({tag, "_z"},    32'(z_o[d]),    32'(exp[7:0]));
        check({tag, "_cout"}, 32'(cout_o[d]), 32'(exp[8]));
        check({tag, "_ovf"},  32'(ovf_o[d]),  32'(exp[9]));
        check({tag, "_zero"}, 32'(zero_o[d]), 32'(exp[10]));
    endtask

    task automatic junk_inputs(input int d, input logic v);
        in_valid[d] = v;
        a_i[d]      = 8'($urandom);
        b_i[d]      = 8'($urandom);
        sub_i[d]    = 1'($urandom);
    endtask

    // Starts and completes one operation; expects to be entered #1 after a posedge in IDLE.
    task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] y,
                          input logic s, input int stall);
        logic [10:0] exp;
        int          cyc;
        exp = model(x, y, s);
        check("in_ready_idle", 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b1;
        a_i[d]      = x;
        b_i[d]      = y;
        sub_i[d]    = s;
        @(posedge clk); #1;
        junk_inputs(d, stall > 0);
        check("in_ready_busy", 32'(in_ready[d]), 32'd0);
        cyc = 0;
        while (!out_valid[d] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(nchunk[d]));
        check_result(d, "res", exp);
        for (int i = 0; i < stall; i++) begin
            junk_inputs(d, 1'b1);
            @(posedge clk); #1;
            check("stall_vld", 32'(out_valid[d]), 32'd1);
            check("stall_rdy", 32'(in_ready[d]), 32'd0);
            check_result(d, "stall", exp);
        end
        out_ready[d] = 1'b1;
        junk_inputs(d, 1'b1);
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        in_valid[d]  = 1'b0;
        check("post_vld", 32'(out_valid[d]), 32'd0);
        check("post_rdy", 32'(in_ready[d]), 32'd1);
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] y;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            a_i[d]       = 8'h00;
            b_i[d]       = 8'h00;
            sub_i[d]     = 1'b0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", 32'(in_ready[d]), 32'd1);
            check("rst_out_valid", 32'(out_valid[d]), 32'd0);
            check_result(d, "rst", 11'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(0, 8'hFF, 8'h01, 1'b0, 0);
        run_op(0, 8'h7F, 8'h01, 1'b0, 0);
        run_op(0, 8'h05, 8'h07, 1'b1, 0);
        run_op(0, 8'h44, 8'h44, 1'b1, 5);
        run_op(0, 8'h80, 8'h01, 1'b1, 5);
        run_op(1, 8'h40, 8'h40, 1'b0, 0);
        run_op(1, 8'h80, 8'h01, 1'b1, 2);

        // Asynchronous reset in the middle of RUN, after one chunk has been written.
        in_valid[0] = 1'b1;
        a_i[0]      = 8'h12;
        b_i[0]      = 8'h34;
        sub_i[0]    = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
        check_result(0, "mid_rst", 11'h000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("no_result_after_rst", 32'(out_valid[0]), 32'd0);
        end

        for (int n = 0; n < 200; n++) begin
            x = 8'($urandom);
            y = ($urandom_range(0, 7) == 0) ? x : 8'($urandom);
            run_op(n % 4 == 3 ? 1 : 0, x, y, 1'($urandom), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
